// File: rtl/axi_write_mux_if.sv
// rtl/axi_write_mux_if.sv - Bus bundle between the 4 write masters, the write arbiter and the shared slave port
interface axi_write_mux_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 8
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   // Arbiter grant
   logic [3:0]                wgrnt;

   // Master-side AW / W / B (packed, master i at [i*W +: W])
   logic [4*ID_WIDTH-1:0]     m_AWID;
   logic [4*ADDR_WIDTH-1:0]   m_AWADDR;
   logic [4*LEN_WIDTH-1:0]    m_AWLEN;
   logic [4*3-1:0]            m_AWSIZE;
   logic [4*2-1:0]            m_AWBURST;
   logic [3:0]                m_AWVALID;
   logic [3:0]                m_AWREADY;
   logic [4*DATA_WIDTH-1:0]   m_WDATA;
   logic [4*STRB_WIDTH-1:0]   m_WSTRB;
   logic [3:0]                m_WLAST;
   logic [3:0]                m_WVALID;
   logic [3:0]                m_WREADY;
   logic [4*ID_WIDTH-1:0]     m_BID;
   logic [4*2-1:0]            m_BRESP;
   logic [3:0]                m_BVALID;
   logic [3:0]                m_BREADY;

   // Slave-side AW / W / B
   logic [ID_WIDTH-1:0]       s_AWID;
   logic [ADDR_WIDTH-1:0]     s_AWADDR;
   logic [LEN_WIDTH-1:0]      s_AWLEN;
   logic [2:0]                s_AWSIZE;
   logic [1:0]                s_AWBURST;
   logic                      s_AWVALID;
   logic                      s_AWREADY;
   logic [DATA_WIDTH-1:0]     s_WDATA;
   logic [STRB_WIDTH-1:0]     s_WSTRB;
   logic                      s_WLAST;
   logic                      s_WVALID;
   logic                      s_WREADY;
   logic [ID_WIDTH-1:0]       s_BID;
   logic [1:0]                s_BRESP;
   logic                      s_BVALID;
   logic                      s_BREADY;

   // Status
   logic                      busy;
   logic [1:0]                owner;
   logic                      err_wlast;

   // Mux view
   modport slave (
      input  wgrnt,
      input  m_AWID, m_AWADDR, m_AWLEN, m_AWSIZE, m_AWBURST, m_AWVALID,
      output m_AWREADY,
      input  m_WDATA, m_WSTRB, m_WLAST, m_WVALID,
      output m_WREADY,
      output m_BID, m_BRESP, m_BVALID,
      input  m_BREADY,
      output s_AWID, s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST, s_AWVALID,
      input  s_AWREADY,
      output s_WDATA, s_WSTRB, s_WLAST, s_WVALID,
      input  s_WREADY,
      input  s_BID, s_BRESP, s_BVALID,
      output s_BREADY,
      output busy, owner, err_wlast
   );

   // Environment view (masters, arbiter and slave together)
   modport master (
      output wgrnt,
      output m_AWID, m_AWADDR, m_AWLEN, m_AWSIZE, m_AWBURST, m_AWVALID,
      input  m_AWREADY,
      output m_WDATA, m_WSTRB, m_WLAST, m_WVALID,
      input  m_WREADY,
      input  m_BID, m_BRESP, m_BVALID,
      output m_BREADY,
      input  s_AWID, s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST, s_AWVALID,
      output s_AWREADY,
      input  s_WDATA, s_WSTRB, s_WLAST, s_WVALID,
      output s_WREADY,
      output s_BID, s_BRESP, s_BVALID,
      input  s_BREADY,
      input  busy, owner, err_wlast
   );
endinterface

// File: rtl/axi_write_mux.sv
// rtl/axi_write_mux.sv - 4:1 AXI write-channel switch locked to the granted master for a whole burst
module axi_write_mux #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 8
) (
   input  logic               ACLK,
   input  logic               ARESET,
   axi_write_mux_if.slave     bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_ADDR = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_owner;
   logic [LEN_WIDTH-1:0]  r_beat_cnt;
   logic [LEN_WIDTH-1:0]  r_len_q;
   logic                  r_err_wlast;

   logic                  w_grant_ok;
   logic [1:0]            w_gidx;
   logic                  w_wlast;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_s_awvalid;
   logic [3:0]            w_m_awready;
   logic                  w_s_wvalid;
   logic [3:0]            w_m_wready;
   logic                  w_s_bready;
   logic [3:0]            w_m_bvalid;

   // Decode the arbiter grant; anything other than exactly one bit set is treated as no grant
   always_comb begin
      w_grant_ok = 1'b0;
      w_gidx     = 2'd0;
      case (bus.wgrnt)
         4'b0001: begin w_grant_ok = 1'b1; w_gidx = 2'd0; end
         4'b0010: begin w_grant_ok = 1'b1; w_gidx = 2'd1; end
         4'b0100: begin w_grant_ok = 1'b1; w_gidx = 2'd2; end
         4'b1000: begin w_grant_ok = 1'b1; w_gidx = 2'd3; end
         default: begin w_grant_ok = 1'b0; w_gidx = 2'd0; end
      endcase
   end

   // Payloads always follow the grant (AW) or the locked owner (W); only valids/readies are gated
   assign bus.s_AWID    = bus.m_AWID   [int'(w_gidx)*ID_WIDTH   +: ID_WIDTH];
   assign bus.s_AWADDR  = bus.m_AWADDR [int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign bus.s_AWLEN   = bus.m_AWLEN  [int'(w_gidx)*LEN_WIDTH  +: LEN_WIDTH];
   assign bus.s_AWSIZE  = bus.m_AWSIZE [int'(w_gidx)*3          +: 3];
   assign bus.s_AWBURST = bus.m_AWBURST[int'(w_gidx)*2          +: 2];
   assign bus.s_WDATA   = bus.m_WDATA  [int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
   assign bus.s_WSTRB   = bus.m_WSTRB  [int'(r_owner)*STRB_WIDTH +: STRB_WIDTH];
   assign bus.m_BID     = {4{bus.s_BID}};
   assign bus.m_BRESP   = {4{bus.s_BRESP}};

   // Last beat comes from our own counter, never from the master's flag
   assign w_wlast       = (r_state == ST_DATA) && (r_beat_cnt == r_len_q);
   assign bus.s_WLAST   = w_wlast;

   assign bus.s_AWVALID = w_s_awvalid;
   assign bus.m_AWREADY = w_m_awready;
   assign bus.s_WVALID  = w_s_wvalid;
   assign bus.m_WREADY  = w_m_wready;
   assign bus.s_BREADY  = w_s_bready;
   assign bus.m_BVALID  = w_m_bvalid;
   assign bus.busy      = (r_state != ST_ADDR);
   assign bus.owner     = r_owner;
   assign bus.err_wlast = r_err_wlast;

   // Next-state and channel gating: only the phase matching the current state is open
   always_comb begin
      w_state_nxt = r_state;
      w_s_awvalid = 1'b0;
      w_m_awready = 4'b0000;
      w_s_wvalid  = 1'b0;
      w_m_wready  = 4'b0000;
      w_s_bready  = 1'b0;
      w_m_bvalid  = 4'b0000;
      w_aw_hs     = 1'b0;
      w_w_hs      = 1'b0;
      w_b_hs      = 1'b0;
      case (r_state)
         ST_ADDR: begin
            // Reset closes the AW path immediately even though the state already reads ADDR
            if (w_grant_ok && !ARESET) begin
               w_s_awvalid         = bus.m_AWVALID[w_gidx];
               w_m_awready[w_gidx] = bus.s_AWREADY;
               w_aw_hs             = bus.m_AWVALID[w_gidx] & bus.s_AWREADY;
            end
            if (w_aw_hs) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            w_s_wvalid           = bus.m_WVALID[r_owner];
            w_m_wready[r_owner]  = bus.s_WREADY;
            w_w_hs               = bus.m_WVALID[r_owner] & bus.s_WREADY;
            if (w_w_hs && w_wlast) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            w_m_bvalid[r_owner]  = bus.s_BVALID;
            w_s_bready           = bus.m_BREADY[r_owner];
            w_b_hs               = bus.s_BVALID & bus.m_BREADY[r_owner];
            if (w_b_hs) w_state_nxt = ST_ADDR;
         end
         default: w_state_nxt = ST_ADDR;
      endcase
   end

   // State register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_state <= ST_ADDR;
      else        r_state <= w_state_nxt;
   end

   // Owner lock, burst length capture, beat counting and sticky WLAST-mismatch flag
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_owner     <= 2'd0;
         r_len_q     <= '0;
         r_beat_cnt  <= '0;
         r_err_wlast <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_owner    <= w_gidx;
            r_len_q    <= bus.m_AWLEN[int'(w_gidx)*LEN_WIDTH +: LEN_WIDTH];
            r_beat_cnt <= '0;
         end
         if (w_w_hs) begin
            if (bus.m_WLAST[r_owner] != w_wlast) r_err_wlast <= 1'b1;
            if (!w_wlast) r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axi_write_mux.sv
// tb/tb_axi_write_mux.sv - Randomized self-checking bench for axi_write_mux
module tb_axi_write_mux;
   logic ACLK;
   logic ARESET;
   int   n_checks;
   int   n_fail;
   logic model_err;

   axi_write_mux_if bus ();

   axi_write_mux dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   always #5 ACLK = ~ACLK;

   // Stimulus per transaction and what the slave/master sides showed
   logic [31:0] exp_data [0:15];
   logic [3:0]  exp_strb [0:15];
   logic        exp_mlast[0:15];
   logic [3:0]  exp_id;
   logic [31:0] obs_wdata[0:15];
   logic [3:0]  obs_wstrb[0:15];
   logic        obs_wlast[0:15];
   logic        obs_err  [0:15];
   logic [31:0] obs_awaddr;
   logic [7:0]  obs_awlen;
   logic [3:0]  obs_awid;
   logic [3:0]  obs_awready;
   logic [3:0]  obs_bvalid;
   logic [3:0]  obs_bid;
   logic [1:0]  obs_bresp;
   logic        obs_timeout, obs_w_leak, obs_owner_bad, obs_aw_leak, obs_bvalid_bad, obs_busy_after;
   int          obs_beats;

   task automatic rand_inputs();
      bus.m_AWID    = 16'($urandom);
      bus.m_AWADDR  = {$urandom, $urandom, $urandom, $urandom};
      bus.m_AWLEN   = $urandom;
      bus.m_AWSIZE  = 12'($urandom);
      bus.m_AWBURST = 8'($urandom);
      bus.m_AWVALID = 4'($urandom);
      bus.m_WDATA   = {$urandom, $urandom, $urandom, $urandom};
      bus.m_WSTRB   = 16'($urandom);
      bus.m_WLAST   = 4'($urandom);
      bus.m_WVALID  = 4'($urandom);
      bus.m_BREADY  = 4'($urandom);
      bus.s_BID     = 4'($urandom);
      bus.s_BRESP   = 2'($urandom);
   endtask

   task automatic idle_inputs();
      bus.wgrnt     = 4'b0000;
      bus.m_AWVALID = 4'b0000;
      bus.m_WVALID  = 4'b0000;
      bus.s_AWREADY = 1'b0;
      bus.s_WREADY  = 1'b0;
      bus.s_BVALID  = 1'b0;
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      rand_inputs();
      idle_inputs();
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
      model_err = 1'b0;
   endtask

   // Drives one full AW/W/B transaction from master m and records what the DUT presented
   task automatic run_txn(input int m, input int len, input logic [3:0] g_after, input int bad,
                          input int wmode, input logic [1:0] bresp, input logic [31:0] addr,
                          input logic [31:0] d0);
      int  k, cyc, err_pend;
      logic hs;
      exp_id = 4'($urandom);
      for (int i = 0; i <= len; i++) begin
         exp_data[i]  = (i == 0) ? d0 : $urandom;
         exp_strb[i]  = 4'($urandom);
         exp_mlast[i] = (i == len) ^ (i == bad);
         obs_err[i]   = 1'bx;
      end
      obs_timeout = 0; obs_w_leak = 0; obs_owner_bad = 0; obs_aw_leak = 0; obs_bvalid_bad = 0;
      obs_bvalid = 4'b0; obs_beats = 0; err_pend = -1;
      @(posedge ACLK); #1;
      // Address phase
      hs = 0; cyc = 0;
      while (!hs && cyc < 20) begin
         rand_inputs();
         bus.wgrnt = 4'b0001 << m;
         bus.m_AWADDR[m*32 +: 32] = addr;
         bus.m_AWLEN[m*8 +: 8]    = 8'(len);
         bus.m_AWID[m*4 +: 4]     = exp_id;
         bus.m_AWVALID[m]         = 1'b1;
         bus.m_WVALID             = 4'b0000;
         bus.s_AWREADY            = (cyc >= 2) ? 1'b1 : 1'($urandom);
         bus.s_WREADY = 1'b1; bus.s_BVALID = 1'b1;
         @(negedge ACLK);
         hs = bus.s_AWVALID && bus.s_AWREADY;
         if (hs) begin
            obs_awaddr = bus.s_AWADDR; obs_awlen = bus.s_AWLEN;
            obs_awid = bus.s_AWID; obs_awready = bus.m_AWREADY;
         end
         @(posedge ACLK); #1; cyc++;
      end
      if (!hs) obs_timeout = 1;
      // Data phase
      k = 0; cyc = 0; bus.s_BVALID = 1'b0;
      while (!obs_timeout && k <= len && cyc < 200) begin
         rand_inputs();
         bus.wgrnt = g_after;
         bus.s_AWREADY = 1'b1;
         bus.m_WDATA[m*32 +: 32] = exp_data[k];
         bus.m_WSTRB[m*4 +: 4]   = exp_strb[k];
         bus.m_WLAST[m]          = exp_mlast[k];
         bus.m_WVALID[m]         = 1'b1;
         bus.s_WREADY = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'(cyc % 2) : 1'($urandom);
         @(negedge ACLK);
         if (err_pend >= 0) begin obs_err[err_pend] = bus.err_wlast; err_pend = -1; end
         if (bus.owner !== 2'(m)) obs_owner_bad = 1;
         if (bus.s_AWVALID !== 1'b0 || bus.m_AWREADY !== 4'b0) obs_aw_leak = 1;
         if ((bus.m_WREADY & ~(4'b0001 << m)) !== 4'b0) obs_w_leak = 1;
         if (bus.m_BVALID !== 4'b0) obs_bvalid_bad = 1;
         hs = bus.s_WVALID && bus.s_WREADY;
         if (hs) begin
            obs_wdata[k] = bus.s_WDATA; obs_wstrb[k] = bus.s_WSTRB; obs_wlast[k] = bus.s_WLAST;
            err_pend = k;
         end
         @(posedge ACLK); #1;
         if (hs) k++;
         cyc++;
      end
      obs_beats = k;
      if (k <= len) obs_timeout = 1;
      // Response phase
      hs = 0; cyc = 0;
      while (!obs_timeout && !hs && cyc < 50) begin
         rand_inputs();
         bus.wgrnt = 4'($urandom);
         bus.s_AWREADY = 1'b1; bus.s_WREADY = 1'b1;
         bus.s_BID = exp_id; bus.s_BRESP = bresp; bus.s_BVALID = 1'b1;
         bus.m_BREADY[m] = (cyc >= 3) ? 1'b1 : 1'($urandom);
         @(negedge ACLK);
         if (err_pend >= 0) begin obs_err[err_pend] = bus.err_wlast; err_pend = -1; end
         if (bus.owner !== 2'(m)) obs_owner_bad = 1;
         if (bus.s_AWVALID !== 1'b0 || bus.m_AWREADY !== 4'b0) obs_aw_leak = 1;
         if (bus.m_WREADY !== 4'b0 || bus.s_WVALID !== 1'b0) obs_w_leak = 1;
         if ((bus.m_BVALID & ~(4'b0001 << m)) !== 4'b0) obs_bvalid_bad = 1;
         hs = bus.s_BVALID && bus.s_BREADY;
         if (hs) begin
            obs_bvalid = bus.m_BVALID; obs_bid = bus.m_BID[m*4 +: 4]; obs_bresp = bus.m_BRESP[m*2 +: 2];
         end
         @(posedge ACLK); #1; cyc++;
      end
      if (!hs) obs_timeout = 1;
      idle_inputs();
      @(negedge ACLK);
      obs_busy_after = bus.busy;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      for (int c = 0; c < 3; c++) begin
         rand_inputs();
         bus.wgrnt = 4'b0001 << (c % 4);
         bus.s_AWREADY = 1'b1; bus.s_WREADY = 1'b1; bus.s_BVALID = 1'b1;
         @(negedge ACLK);
         n_checks++; if (bus.m_AWREADY !== 4'b0) begin n_fail++; $display("FAIL reset_awready: got %b expected 0000", bus.m_AWREADY); end
         n_checks++; if (bus.m_WREADY !== 4'b0) begin n_fail++; $display("FAIL reset_wready: got %b expected 0000", bus.m_WREADY); end
         n_checks++; if (bus.m_BVALID !== 4'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b expected 0000", bus.m_BVALID); end
         n_checks++; if (bus.s_WVALID !== 1'b0 || bus.s_BREADY !== 1'b0) begin n_fail++; $display("FAIL reset_s_wvalid_bready: got %b%b expected 00", bus.s_WVALID, bus.s_BREADY); end
         n_checks++; if (bus.busy !== 1'b0 || bus.owner !== 2'd0 || bus.err_wlast !== 1'b0) begin n_fail++; $display("FAIL reset_status: got busy=%b owner=%0d err=%b expected 0/0/0", bus.busy, bus.owner, bus.err_wlast); end
         @(posedge ACLK);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      run_txn(0, 0, 4'b0001, -1, 0, 2'b00, 32'h0000_1000, 32'hA5A5_A5A5);
      n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b expected 0", obs_timeout); end
      n_checks++; if (obs_awaddr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_awaddr: got %h expected 00001000", obs_awaddr); end
      n_checks++; if (obs_awready !== 4'b0001) begin n_fail++; $display("FAIL single_awready: got %b expected 0001", obs_awready); end
      n_checks++; if (obs_wdata[0] !== 32'hA5A5_A5A5 || obs_wlast[0] !== 1'b1) begin n_fail++; $display("FAIL single_wbeat: got %h last=%b expected a5a5a5a5 last=1", obs_wdata[0], obs_wlast[0]); end
      n_checks++; if (obs_bvalid !== 4'b0001 || obs_bresp !== 2'b00) begin n_fail++; $display("FAIL single_b: got bvalid=%b bresp=%b expected 0001/00", obs_bvalid, obs_bresp); end
      n_checks++; if (obs_busy_after !== 1'b0 || bus.err_wlast !== 1'b0) begin n_fail++; $display("FAIL single_end: got busy=%b err=%b expected 0/0", obs_busy_after, bus.err_wlast); end
   endtask

   task automatic test_grant_switch();
      do_reset();
      run_txn(2, 3, 4'b1000, -1, 1, 2'b00, $urandom, $urandom);
      n_checks++; if (obs_timeout !== 1'b0 || obs_beats !== 4) begin n_fail++; $display("FAIL switch_beats: got %0d timeout=%b expected 4/0", obs_beats, obs_timeout); end
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (obs_wdata[k] !== exp_data[k]) begin n_fail++; $display("FAIL switch_wdata[%0d]: got %h expected %h", k, obs_wdata[k], exp_data[k]); end
         n_checks++; if (obs_wlast[k] !== (k == 3)) begin n_fail++; $display("FAIL switch_wlast[%0d]: got %b expected %b", k, obs_wlast[k], k == 3); end
      end
      n_checks++; if (obs_w_leak !== 1'b0 || obs_bvalid_bad !== 1'b0) begin n_fail++; $display("FAIL switch_leak: got wleak=%b bleak=%b expected 0/0", obs_w_leak, obs_bvalid_bad); end
      n_checks++; if (obs_owner_bad !== 1'b0 || obs_aw_leak !== 1'b0) begin n_fail++; $display("FAIL switch_owner: got owner_bad=%b aw_leak=%b expected 0/0", obs_owner_bad, obs_aw_leak); end
      n_checks++; if (obs_bvalid !== 4'b0100) begin n_fail++; $display("FAIL switch_bvalid: got %b expected 0100", obs_bvalid); end
   endtask

   task automatic test_wlast_err();
      do_reset();
      run_txn(1, 2, 4'($urandom), 1, 2, 2'b00, $urandom, $urandom);
      n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL wlerr_timeout: got %b expected 0", obs_timeout); end
      n_checks++; if (obs_err[0] !== 1'b0) begin n_fail++; $display("FAIL wlerr_beat1: got %b expected 0", obs_err[0]); end
      n_checks++; if (obs_err[1] !== 1'b1 || obs_err[2] !== 1'b1) begin n_fail++; $display("FAIL wlerr_sticky: got %b%b expected 11", obs_err[1], obs_err[2]); end
      n_checks++; if (obs_wlast[1] !== 1'b0 || obs_wlast[2] !== 1'b1) begin n_fail++; $display("FAIL wlerr_slast: got %b%b expected 01", obs_wlast[1], obs_wlast[2]); end
      n_checks++; if (obs_bvalid !== 4'b0010 || obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL wlerr_done: got bvalid=%b busy=%b expected 0010/0", obs_bvalid, obs_busy_after); end
      n_checks++; if (bus.err_wlast !== 1'b1) begin n_fail++; $display("FAIL wlerr_hold: got %b expected 1", bus.err_wlast); end
   endtask

   task automatic test_bad_grant();
      logic [3:0] grants [0:1];
      grants[0] = 4'b0000; grants[1] = 4'b0110;
      do_reset();
      @(posedge ACLK); #1;
      for (int i = 0; i < 2; i++) begin
         rand_inputs();
         bus.wgrnt = grants[i]; bus.m_AWVALID = 4'b0110; bus.m_WVALID = 4'b0; bus.s_AWREADY = 1'b1;
         @(negedge ACLK);
         n_checks++; if (bus.s_AWVALID !== 1'b0 || bus.m_AWREADY !== 4'b0) begin n_fail++; $display("FAIL badgrant_%b: got awvalid=%b awready=%b expected 0/0000", grants[i], bus.s_AWVALID, bus.m_AWREADY); end
         @(posedge ACLK); #1;
      end
      idle_inputs();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL badgrant_busy: got %b expected 0", bus.busy); end
      run_txn(1, 1, 4'b0010, -1, 0, 2'b10, 32'h0000_2468, $urandom);
      n_checks++; if (obs_timeout !== 1'b0 || obs_awaddr !== 32'h0000_2468 || obs_awready !== 4'b0010) begin n_fail++; $display("FAIL badgrant_accept: got addr=%h awready=%b timeout=%b expected 00002468/0010/0", obs_awaddr, obs_awready, obs_timeout); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(posedge ACLK); #1;
      bus.wgrnt = 4'b0001; bus.m_AWVALID = 4'b0001; bus.m_AWLEN[7:0] = 8'd3; bus.s_AWREADY = 1'b1;
      @(posedge ACLK); #1;
      bus.m_AWVALID = 4'b0; bus.m_WVALID = 4'b0001; bus.m_WLAST = 4'b0; bus.s_WREADY = 1'b1;
      @(posedge ACLK); #1;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %b expected 1", bus.busy); end
      #2 ARESET = 1'b1;
      #1;
      n_checks++; if (bus.busy !== 1'b0 || bus.m_WREADY !== 4'b0 || bus.s_WVALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: got busy=%b wready=%b wvalid=%b expected 0/0000/0", bus.busy, bus.m_WREADY, bus.s_WVALID); end
      @(posedge ACLK); #1;
      ARESET = 1'b0; model_err = 1'b0;
      idle_inputs();
      run_txn(3, 2, 4'($urandom), -1, 2, 2'b01, $urandom, $urandom);
      n_checks++; if (obs_timeout !== 1'b0 || obs_beats !== 3) begin n_fail++; $display("FAIL rstmid_fresh: got beats=%0d timeout=%b expected 3/0", obs_beats, obs_timeout); end
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (obs_wdata[k] !== exp_data[k]) begin n_fail++; $display("FAIL rstmid_wdata[%0d]: got %h expected %h", k, obs_wdata[k], exp_data[k]); end
      end
      n_checks++; if (obs_bvalid !== 4'b1000 || obs_bresp !== 2'b01 || bus.err_wlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_b: got bvalid=%b bresp=%b err=%b expected 1000/01/0", obs_bvalid, obs_bresp, bus.err_wlast); end
   endtask

   task automatic test_random();
      int m, len, bad;
      logic [1:0]  bresp;
      logic [31:0] addr;
      do_reset();
      for (int t = 0; t < 25; t++) begin
         m     = $urandom_range(0, 3);
         len   = $urandom_range(0, 7);
         bad   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
         bresp = 2'($urandom);
         addr  = $urandom;
         run_txn(m, len, 4'($urandom), bad, 2, bresp, addr, $urandom);
         n_checks++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b expected 0", t, obs_timeout); end
         n_checks++; if (obs_awaddr !== addr || obs_awlen !== 8'(len) || obs_awid !== exp_id) begin n_fail++; $display("FAIL rand%0d_aw: got %h/%0d/%h expected %h/%0d/%h", t, obs_awaddr, obs_awlen, obs_awid, addr, len, exp_id); end
         n_checks++; if (obs_awready !== (4'b0001 << m)) begin n_fail++; $display("FAIL rand%0d_awready: got %b expected %b", t, obs_awready, 4'b0001 << m); end
         for (int k = 0; k <= len; k++) begin
            model_err = model_err | (exp_mlast[k] != (k == len));
            n_checks++; if (obs_wdata[k] !== exp_data[k] || obs_wstrb[k] !== exp_strb[k]) begin n_fail++; $display("FAIL rand%0d_w[%0d]: got %h/%h expected %h/%h", t, k, obs_wdata[k], obs_wstrb[k], exp_data[k], exp_strb[k]); end
            n_checks++; if (obs_wlast[k] !== (k == len)) begin n_fail++; $display("FAIL rand%0d_wlast[%0d]: got %b expected %b", t, k, obs_wlast[k], k == len); end
            n_checks++; if (obs_err[k] !== model_err) begin n_fail++; $display("FAIL rand%0d_err[%0d]: got %b expected %b", t, k, obs_err[k], model_err); end
         end
         n_checks++; if (obs_bvalid !== (4'b0001 << m) || obs_bid !== exp_id || obs_bresp !== bresp) begin n_fail++; $display("FAIL rand%0d_b: got %b/%h/%b expected %b/%h/%b", t, obs_bvalid, obs_bid, obs_bresp, 4'b0001 << m, exp_id, bresp); end
         n_checks++; if ({obs_w_leak, obs_aw_leak, obs_bvalid_bad, obs_owner_bad} !== 4'b0) begin n_fail++; $display("FAIL rand%0d_isolation: got w/aw/b/owner=%b%b%b%b expected 0000", t, obs_w_leak, obs_aw_leak, obs_bvalid_bad, obs_owner_bad); end
         n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got %b expected 0", t, obs_busy_after); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      model_err = 1'b0;
      ACLK      = 1'b0;
      ARESET    = 1'b1;
      rand_inputs();
      idle_inputs();
      test_reset();
      test_single();
      test_grant_switch();
      test_wlast_err();
      test_bad_grant();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
